// File: rtl/sobol_seq_gen_if.sv
// -----------------------------------------------------------------------------
// sobol_seq_gen_if
//
// Purpose : Output stream of the Sobol generator toward the INT32-to-FP16
//           converter. The generator is the master, the converter the slave.
//
// Signals :
//   out_valid  master -> slave  out_data holds a valid sample
//   out_ready  slave  -> master sample is accepted on this clock edge
//   out_data   master -> slave  32-bit unsigned fixed-point sample (x / 2^32)
// -----------------------------------------------------------------------------
interface sobol_seq_gen_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface : sobol_seq_gen_if

// File: rtl/sobol_seq_gen.sv
// -----------------------------------------------------------------------------
// sobol_seq_gen
//
// Purpose : Single-dimension Sobol sequence generator, Gray-code recurrence.
//           Each run, started by a pulse on start, emits num_samples samples
//           x_1, x_2, ... over a valid/ready stream.
//             x_1     = v[0]
//             x_{n+1} = x_n ^ v[c(n)],  c(n) = index of lowest zero bit of n
//
// Optional feature macro : SOBOL_DV_LOAD_EN
//   defined   : dv_wr/dv_addr/dv_data ports exist; the direction table is a
//               writable register file (writes land only in IDLE, and only
//               when start is low in the same cycle).
//   undefined : ports absent; table is the constant van der Corput set.
//
// Ports :
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        run request, sampled only in IDLE
//   num_samples  samples to emit, captured when start is accepted
//   dv_wr        direction-vector write strobe   (SOBOL_DV_LOAD_EN only)
//   dv_addr      direction-vector index 0..31     (SOBOL_DV_LOAD_EN only)
//   dv_data      direction-vector value           (SOBOL_DV_LOAD_EN only)
//   out_if       master side of the sample stream (out_valid/out_ready/out_data)
//   busy         high in RUN and DONE
//   done         one-cycle pulse after the last sample is accepted
// -----------------------------------------------------------------------------
module sobol_seq_gen #(
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num_samples,
`ifdef SOBOL_DV_LOAD_EN
    input  logic             dv_wr,
    input  logic [4:0]       dv_addr,
    input  logic [31:0]      dv_data,
`endif
    sobol_seq_gen_if.master  out_if,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default direction vectors: v[k] = 1 << (31-k) (van der Corput).
    function automatic logic [31:0] dv_default(input int k);
        return 32'h8000_0000 >> k;
    endfunction

    state_e           state_q, state_d;
    logic [31:0]      x_q, x_d;
    logic [NUM_W-1:0] n_q, n_d;
    logic [NUM_W-1:0] rem_q, rem_d;

    logic [31:0]      dv_q [32];
    logic             accept;
    logic [5:0]       c_idx;
    logic [31:0]      v_sel;

    assign accept = (state_q == ST_RUN) && out_if.out_ready;

    // -------------------------------------------------------------------------
    // Direction table
    // -------------------------------------------------------------------------
`ifdef SOBOL_DV_LOAD_EN
    logic dv_we;

    // A write competing with an accepted start is dropped so a run never sees
    // a table that changes under its first sample.
    assign dv_we = dv_wr && (state_q == ST_IDLE) && !start;

    // NOTE: the table is a flop array, not a RAM, because reset must restore
    // every entry to its default asynchronously; a RAM macro cannot do that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin
                dv_q[k] <= dv_default(k);
            end
        end else if (dv_we) begin
            dv_q[dv_addr] <= dv_data;
        end
    end
`else
    for (genvar k = 0; k < 32; k++) begin : g_dv_const
        assign dv_q[k] = dv_default(k);
    end
`endif

    // -------------------------------------------------------------------------
    // c(n): lowest zero bit of the registered index. An all-ones index yields
    // NUM_W; indices beyond the table select a zero vector.
    // -------------------------------------------------------------------------
    always_comb begin
        c_idx = 6'(NUM_W);
        for (int i = NUM_W - 1; i >= 0; i--) begin
            if (!n_q[i]) begin
                c_idx = 6'(i);
            end
        end
    end

    assign v_sel = (c_idx < 6'd32) ? dv_q[c_idx[4:0]] : 32'h0;

    // -------------------------------------------------------------------------
    // FSM and datapath, next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every _d is given its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        rem_d   = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_samples != '0) begin
                        state_d = ST_RUN;
                        x_d     = dv_q[0];
                        n_d     = NUM_W'(1);
                        rem_d   = num_samples;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                if (accept) begin
                    x_d   = x_q ^ v_sel;
                    n_d   = n_q + NUM_W'(1);
                    rem_d = rem_q - NUM_W'(1);
                    if (rem_q == NUM_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            n_q     <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registers, nothing depends on out_ready
    // -------------------------------------------------------------------------
    assign out_if.out_valid = (state_q == ST_RUN);
    assign out_if.out_data  = x_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);

endmodule : sobol_seq_gen
